ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource between N requesters. The rotating priority pointer is a one-hot ring register that shifts with wrap-around. Each grant is one-hot and registered. A grant is held until the requester drops its request or the hold limit expires. The block sits between the requesting units and the shared datapath and drives that datapath's select and enable.

---
 rtl/ring_rr_arbiter_if.sv | 25 ++
 rtl/ring_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between the requesting units (master) and the arbiter (slave).
// The arbiter drives the select/enable side that feeds the shared datapath.
interface ring_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;
    logic           timeout;

    modport master (
        output en, req,
        input  gnt, gnt_valid, gnt_id, ptr, timeout
    );

    modport slave (
        input  en, req,
        output gnt, gnt_valid, gnt_id, ptr, timeout
    );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and a bounded grant hold time.
// Grants are registered, one-hot, and held until the owner drops its request or HOLD_MAX expires.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    ring_rr_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(HOLD_MAX) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]     state_q,    state_d;
    logic [N-1:0]   gnt_q,      gnt_d;
    logic [IDW-1:0] gntId_q,    gntId_d;
    logic           gntValid_q, gntValid_d;
    logic [N-1:0]   ptr_q,      ptr_d;
    logic [HW-1:0]  holdCnt_q,  holdCnt_d;
    logic           timeout_q,  timeout_d;

    logic [N-1:0]   relPtr;
    logic [N-1:0]   winIdle;
    logic [N-1:0]   winRel;
    logic           doRelease;
    logic           anyReq;

    // Circular first-set scan of r starting at the bit marked in the one-hot p.
    function automatic logic [N-1:0] pickWinner(input logic [N-1:0] p, input logic [N-1:0] r);
        int   start;
        int   idx;
        logic found;
        pickWinner = '0;
        start      = 0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) start = i;
        end
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) idx = idx - N;
            if (!found && r[idx]) begin
                pickWinner[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    endfunction

    function automatic logic [IDW-1:0] toIndex(input logic [N-1:0] v);
        toIndex = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) toIndex = toIndex | IDW'(i);
        end
    endfunction

    // Releasing owner i hands top priority to i+1; rotating the grant itself gives that ring step.
    assign relPtr  = {gnt_q[N-2:0], gnt_q[N-1]};
    assign winIdle = pickWinner(ptr_q, bus.req);
    assign winRel  = pickWinner(relPtr, bus.req);
    assign anyReq  = |bus.req;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gntId_d    = gntId_q;
        gntValid_d = gntValid_q;
        ptr_d      = ptr_q;
        holdCnt_d  = holdCnt_q;
        timeout_d  = 1'b0;
        doRelease  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en && anyReq) begin
                    gnt_d      = winIdle;
                    gntId_d    = toIndex(winIdle);
                    gntValid_d = 1'b1;
                    holdCnt_d  = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!(|(bus.req & gnt_q))) begin
                    doRelease = 1'b1;
                end else if (holdCnt_q == HOLD_LAST) begin
                    doRelease = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    holdCnt_d = holdCnt_q + HW'(1);
                end

                if (doRelease) begin
                    ptr_d     = relPtr;
                    holdCnt_d = '0;
                    if (bus.en && anyReq) begin
                        gnt_d      = winRel;
                        gntId_d    = toIndex(winRel);
                        gntValid_d = 1'b1;
                        state_d    = GRANT;
                    end else begin
                        gnt_d      = '0;
                        gntId_d    = '0;
                        gntValid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gntId_q    <= '0;
            gntValid_q <= 1'b0;
            ptr_q      <= N'(1);
            holdCnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gntId_q    <= gntId_d;
            gntValid_q <= gntValid_d;
            ptr_q      <= ptr_d;
            holdCnt_q  <= holdCnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gntId_q;
    assign bus.gnt_valid = gntValid_q;
    assign bus.ptr       = ptr_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter with N=4, HOLD_MAX=4 and hand-computed expectations.
module tb_ring_rr_arbiter;
    localparam int N        = 4;
    localparam int HOLD_MAX = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ring_rr_arbiter_if #(.N(N)) arbBus ();

    ring_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (arbBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [N-1:0] q);
        rst        = r;
        arbBus.en  = e;
        arbBus.req = q;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectState(input string tag, input logic [N-1:0] g, input logic [1:0] id,
                               input logic v, input logic [N-1:0] p, input logic t);
        checkOutput({tag, ".gnt"},     32'(arbBus.gnt),       32'(g));
        checkOutput({tag, ".gnt_id"},  32'(arbBus.gnt_id),    32'(id));
        checkOutput({tag, ".valid"},   32'(arbBus.gnt_valid), 32'(v));
        checkOutput({tag, ".ptr"},     32'(arbBus.ptr),       32'(p));
        checkOutput({tag, ".timeout"}, 32'(arbBus.timeout),   32'(t));
    endtask

    initial begin
        logic [N-1:0] g;

        // Reset, then the first grant from pointer bit 0
        applyStimulus(1'b0, 1'b0, 4'b0000);
        step();
        step();
        expectState("reset", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0101);
        step();
        expectState("first", 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0);

        // Owner drops: back-to-back hand-off to requester 2
        applyStimulus(1'b1, 1'b1, 4'b0100);
        step();
        expectState("drop", 4'b0100, 2'd2, 1'b1, 4'b0010, 1'b0);

        // Sole requester 1: four cycles, timeout pulse, immediate re-grant
        applyStimulus(1'b1, 1'b1, 4'b0010);
        step();
        expectState("sole.c1", 4'b0010, 2'd1, 1'b1, 4'b1000, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            step();
            expectState($sformatf("sole.c%0d", c), 4'b0010, 2'd1, 1'b1, 4'b1000, 1'b0);
        end
        step();
        expectState("sole.timeout", 4'b0010, 2'd1, 1'b1, 4'b0100, 1'b1);
        step();
        expectState("sole.regrant", 4'b0010, 2'd1, 1'b1, 4'b0100, 1'b0);

        // Full rotation with all requesters active, including the 3 -> 0 wrap
        applyStimulus(1'b0, 1'b1, 4'b1111);
        step();
        expectState("rot.reset", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b1111);
        step();
        for (int k = 0; k < 5; k++) begin
            g = 4'(1 << (k % 4));
            for (int c = 0; c < HOLD_MAX; c++) begin
                expectState($sformatf("rot.k%0d.c%0d", k, c), g, 2'(k % 4), 1'b1, g, (c == 0 && k > 0));
                step();
            end
        end
        expectState("rot.after", 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1);

        // Enable low lets the current grant run out but blocks the follow-on
        applyStimulus(1'b0, 1'b1, 4'b0011);
        step();
        applyStimulus(1'b1, 1'b1, 4'b0011);
        step();
        expectState("en.grant", 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0011);
        for (int c = 2; c <= 4; c++) begin
            step();
            expectState($sformatf("en.hold%0d", c), 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0);
        end
        step();
        expectState("en.revoke", 4'b0000, 2'd0, 1'b0, 4'b0010, 1'b1);
        step();
        expectState("en.idle", 4'b0000, 2'd0, 1'b0, 4'b0010, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0011);
        step();
        expectState("en.resume", 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0);

        // Reset in the middle of a grant
        applyStimulus(1'b1, 1'b1, 4'b0100);
        step();
        expectState("mid.grant", 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 4'b0100);
        step();
        expectState("mid.reset", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0100);
        step();
        expectState("mid.regrant", 4'b0100, 2'd2, 1'b1, 4'b0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
